// File: rtl/ifd_pkg.sv
// Shared types and parameter checks for the input-side deserializer family.
package ifd_pkg;

    localparam int unsigned IFD_MIN_WIDTH = 2;
    localparam int unsigned IFD_MAX_WIDTH = 32;

    // Word assembly states: waiting for a frame start, or collecting bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ifd_state_t;

    // True when a word width is supported by the assembly logic.
    function automatic bit ifd_width_ok(input int unsigned w);
        return (w >= IFD_MIN_WIDTH) && (w <= IFD_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/ifd_reg.sv
// 1-bit pad input register with clock enable and async active-low reset.
module ifd_reg (
    input  logic clk,
    input  logic resetn,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    // Capture the pad value on enabled edges, hold otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_q <= 1'b0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/ifd_deser.sv
// Pad-side serial receiver: input register, framed word assembly and a
// single-entry valid/ready holding register with sticky error flags.
module ifd_deser
    import ifd_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pad_d,
    input  logic             pad_fs,
    input  logic             sp,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (!ifd_width_ok(WIDTH)) begin : g_bad_width
        $error("ifd_deser: WIDTH out of supported range 2..32");
    end

    logic             w_d_q;
    logic             w_fs_q;
    logic             r_en_q;
    ifd_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_overflow;
    logic             r_frame_err;

    logic [WIDTH-1:0] w_shift_app;
    logic [WIDTH-1:0] w_shift_first;
    logic             w_in_shift;
    logic             w_complete;
    logic             w_hs;
    logic             w_load;
    logic             w_drop;
    logic             w_ferr;

    ifd_reg u_reg_d (
        .clk    (clk),
        .resetn (resetn),
        .i_en   (sp),
        .i_d    (pad_d),
        .o_q    (w_d_q)
    );

    ifd_reg u_reg_fs (
        .clk    (clk),
        .resetn (resetn),
        .i_en   (sp),
        .i_d    (pad_fs),
        .o_q    (w_fs_q)
    );

    // Remember which edges captured a fresh pad sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= sp;
        end
    end

    // Shifter views: current word with the new bit appended, and a fresh word
    // holding only the new bit as its first bit.
    always_comb begin
        w_shift_app   = r_shift;
        w_shift_first = '0;
        if (MSB_FIRST) begin
            w_shift_app   = {r_shift[WIDTH-2:0], w_d_q};
            w_shift_first = WIDTH'(w_d_q);
        end else begin
            w_shift_app   = {w_d_q, r_shift[WIDTH-1:1]};
            w_shift_first = {w_d_q, {(WIDTH-1){1'b0}}};
        end
    end

    // Completion, handshake and error decode for this edge.
    always_comb begin
        w_in_shift = r_en_q && (r_state == SHIFT);
        w_complete = w_in_shift && !w_fs_q && (r_cnt == CNT_LAST);
        w_ferr     = w_in_shift && w_fs_q;
        w_hs       = r_rx_valid && rx_ready;
        w_load     = w_complete && (!r_rx_valid || w_hs);
        w_drop     = w_complete && r_rx_valid && !rx_ready;
    end

    // Assembly FSM: frame detection, bit counting and shifting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (r_en_q) begin
            unique case (r_state)
                IDLE: begin
                    if (w_fs_q) begin
                        r_shift <= w_shift_first;
                        r_cnt   <= CNT_ONE;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_fs_q) begin
                        r_shift <= w_shift_first;
                        r_cnt   <= CNT_ONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_shift <= w_shift_app;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_shift <= w_shift_app;
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Holding register: load a completed word when free or being drained.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_load) begin
            r_rx_data  <= w_shift_app;
            r_rx_valid <= 1'b1;
        end else if (w_hs) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new event wins over a same-edge clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= w_drop | (r_overflow & ~clr_err);
            r_frame_err <= w_ferr | (r_frame_err & ~clr_err);
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ifd_deser.sv
// Bench for ifd_deser: MSB-first and LSB-first instances on shared stimulus,
// checked every cycle against a bit-queue model of the framing rules.
module tb_ifd_deser;

    logic       clk;
    logic       resetn;
    logic       pad_d;
    logic       pad_fs;
    logic       sp;
    logic       rx_ready;
    logic       clr_err;

    logic [7:0] d1_data;
    logic       d1_valid;
    logic       d1_ovf;
    logic       d1_ferr;
    logic [7:0] d0_data;
    logic       d0_valid;
    logic       d0_ovf;
    logic       d0_ferr;

    int n_cmp;
    int n_err;

    // reference model state
    bit         ref_pv;
    bit         ref_pd;
    bit         ref_pfs;
    bit         ref_q[$];
    bit         ref_valid;
    logic [7:0] ref_msb;
    logic [7:0] ref_lsb;
    bit         ref_ovf;
    bit         ref_ferr;

    ifd_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .resetn    (resetn),
        .pad_d     (pad_d),
        .pad_fs    (pad_fs),
        .sp        (sp),
        .rx_data   (d1_data),
        .rx_valid  (d1_valid),
        .rx_ready  (rx_ready),
        .overflow  (d1_ovf),
        .frame_err (d1_ferr),
        .clr_err   (clr_err)
    );

    ifd_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .resetn    (resetn),
        .pad_d     (pad_d),
        .pad_fs    (pad_fs),
        .sp        (sp),
        .rx_data   (d0_data),
        .rx_valid  (d0_valid),
        .rx_ready  (rx_ready),
        .overflow  (d0_ovf),
        .frame_err (d0_ferr),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_w(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        ref_pv    = 1'b0;
        ref_pd    = 1'b0;
        ref_pfs   = 1'b0;
        ref_q.delete();
        ref_valid = 1'b0;
        ref_msb   = 8'h00;
        ref_lsb   = 8'h00;
        ref_ovf   = 1'b0;
        ref_ferr  = 1'b0;
    endtask

    // One clock edge of the model: the bit sampled on the previous edge is
    // framed into a queue; a full queue of 8 bits becomes a word.
    task automatic ref_edge();
        bit hs;
        bit done;
        bit oset;
        bit fset;
        hs   = ref_valid && (rx_ready === 1'b1);
        done = 1'b0;
        oset = 1'b0;
        fset = 1'b0;
        if (ref_pv) begin
            if (ref_pfs) begin
                fset = (ref_q.size() != 0);
                ref_q.delete();
                ref_q.push_back(ref_pd);
            end else if (ref_q.size() != 0) begin
                ref_q.push_back(ref_pd);
                done = (ref_q.size() == 8);
            end
        end
        if (done) begin
            if (!ref_valid || hs) begin
                ref_valid = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    ref_msb[7-i] = ref_q[i];
                    ref_lsb[i]   = ref_q[i];
                end
            end else begin
                oset = 1'b1;
            end
            ref_q.delete();
        end else if (hs) begin
            ref_valid = 1'b0;
        end
        ref_ovf  = oset | (ref_ovf  & !(clr_err === 1'b1));
        ref_ferr = fset | (ref_ferr & !(clr_err === 1'b1));
        ref_pv   = (sp === 1'b1);
        ref_pd   = (pad_d === 1'b1);
        ref_pfs  = (pad_fs === 1'b1);
    endtask

    task automatic check_all();
        chk_w("data_msb",  d1_data,  ref_msb);
        chk_w("data_lsb",  d0_data,  ref_lsb);
        chk_b("valid_msb", d1_valid, ref_valid);
        chk_b("valid_lsb", d0_valid, ref_valid);
        chk_b("ovf_msb",   d1_ovf,   ref_ovf);
        chk_b("ovf_lsb",   d0_ovf,   ref_ovf);
        chk_b("ferr_msb",  d1_ferr,  ref_ferr);
        chk_b("ferr_lsb",  d0_ferr,  ref_ferr);
    endtask

    task automatic step(input logic s, input logic d, input logic fs,
                        input logic rdy, input logic clr);
        sp       = s;
        pad_d    = d;
        pad_fs   = fs;
        rx_ready = rdy;
        clr_err  = clr;
        @(posedge clk);
        ref_edge();
        #1;
        check_all();
    endtask

    // Send the first n bits of w, first bit = w[7], frame start on bit 0.
    task automatic send_bits(input logic [7:0] w, input int n, input logic rdy, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) step(1'b0, 1'($urandom), 1'($urandom), rdy, 1'b0);
            step(1'b1, w[7-i], (i == 0), rdy, 1'b0);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        ref_reset();
        check_all();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic logic rnd_rdy();
        return ($urandom_range(0, 3) != 0);
    endfunction

    function automatic logic rnd_clr();
        return ($urandom_range(0, 29) == 0);
    endfunction

    initial begin
        logic [7:0] w;
        int         n;
        n_cmp    = 0;
        n_err    = 0;
        resetn   = 1'b0;
        pad_d    = 1'b0;
        pad_fs   = 1'b0;
        sp       = 1'b0;
        rx_ready = 1'b0;
        clr_err  = 1'b0;
        ref_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk_b("reset_valid", d1_valid, 1'b0);
        chk_w("reset_data", d1_data, 8'h00);
        @(negedge clk);
        resetn = 1'b1;

        // single word 0xA5, visible two edges after the last pad bit
        send_bits(8'hA5, 8, 1'b1, 1'b0);
        chk_b("single_not_yet", d1_valid, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_b("single_valid", d1_valid, 1'b1);
        chk_w("single_data", d1_data, 8'hA5);
        chk_w("order_lsb_pal", d0_data, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_b("single_1cycle", d1_valid, 1'b0);

        // bit order: 1,1,0,0,0,0,0,0
        send_bits(8'hC0, 8, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_w("order_lsb_03", d0_data, 8'h03);
        chk_w("order_msb_c0", d1_data, 8'hC0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // enable gaps: sp low every other cycle
        send_bits(8'h3C, 8, 1'b1, 1'b1);
        chk_b("gap_not_yet", d1_valid, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_b("gap_valid", d1_valid, 1'b1);
        chk_w("gap_data", d1_data, 8'h3C);
        chk_b("gap_no_ferr", d1_ferr, 1'b0);
        chk_b("gap_no_ovf", d1_ovf, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // overflow: two words back to back with no consumer
        send_bits(8'h11, 8, 1'b0, 1'b0);
        send_bits(8'h22, 8, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_w("ovf_data_kept", d1_data, 8'h11);
        chk_b("ovf_set", d1_ovf, 1'b1);
        chk_b("ovf_valid", d1_valid, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_b("ovf_cleared", d1_ovf, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // framing error: fs on bit 4, then 0x5A from that bit
        send_bits(8'hF0, 4, 1'b1, 1'b0);
        send_bits(8'h5A, 8, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_b("ferr_set", d1_ferr, 1'b1);
        chk_w("ferr_data", d1_data, 8'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_b("ferr_cleared", d1_ferr, 1'b0);

        // reset mid-word: the partial word must never appear
        send_bits(8'h96, 4, 1'b1, 1'b0);
        do_reset();
        chk_b("rst_valid", d1_valid, 1'b0);
        chk_w("rst_data", d1_data, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'(i & 1), 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_b("rst_no_emit", d1_valid, 1'b0);

        // completion on the same edge as a handshake
        send_bits(8'h4B, 8, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_w("hs_first", d1_data, 8'h4B);
        send_bits(8'hE7, 8, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_w("hs_replace", d1_data, 8'hE7);
        chk_b("hs_valid", d1_valid, 1'b1);
        chk_b("hs_no_ovf", d1_ovf, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // randomized framed traffic with stalls, stray frame starts,
        // truncated words, random backpressure and occasional resets
        for (int k = 0; k < 160; k++) begin
            w = 8'($urandom);
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 8;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, 1'($urandom), 1'($urandom), rnd_rdy(), rnd_clr());
                step(1'b1, w[7-i], (i == 0) || ($urandom_range(0, 39) == 0),
                     rnd_rdy(), rnd_clr());
            end
            if ($urandom_range(0, 2) == 0)
                step(1'($urandom), 1'($urandom), 1'b0, rnd_rdy(), rnd_clr());
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifd_deser.md
# ifd_deser

Input-side capture and deserializer for a pad-level serial link: registers `pad_d`/`pad_fs` in an input flop with clock enable (the IOL input register), assembles `WIDTH`-bit words framed by a frame-start strobe, and presents them on a valid/ready interface. It is the receive counterpart to the output-register path, which drives serial data onto pads. It sits between the I/O pads and fabric consumers such as FIFOs and sensor/host bridges.

## Interface
- `WIDTH`, 8, bits per word; legal range 2..32.
- `MSB_FIRST`, 1, 1 = first received bit lands in `rx_data[WIDTH-1]`; 0 = first bit lands in `rx_data[0]`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `resetn`  in  1  asynchronous, active-low reset.
- `pad_d`  in  1  serial data from pad.
- `pad_fs`  in  1  frame-start strobe from pad; high during the first bit of a word.
- `sp`  in  1  sample enable, active high; gates the input register.
- `rx_data`  out  WIDTH  assembled word.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_ready`  in  1  consumer accepts the word on `rx_valid && rx_ready`.
- `overflow`  out  1  sticky: a completed word was dropped.
- `frame_err`  out  1  sticky: `pad_fs` seen mid-word.
- `clr_err`  in  1  synchronous clear of both sticky flags.

## Operation
- **Input stage.** On each `clk` edge with `sp`=1, `d_q`<=`pad_d` and `fs_q`<=`pad_fs`; `en_q`<=`sp` every edge. `d_q` and `fs_q` hold their value when `sp`=0.
- **Assembly FSM.** States IDLE and SHIFT. It acts only on edges where `en_q`=1.
  - IDLE, `fs_q`=1: place `d_q` as bit 0 of the word and set `cnt`=1. Go to SHIFT, or complete the word immediately if `WIDTH`=1 (illegal; not supported).
  - IDLE, `fs_q`=0: the bit is discarded.
  - SHIFT, `fs_q`=0: append `d_q` and increment `cnt`.
  - SHIFT, `cnt`==`WIDTH`-1 (last bit): the word is complete. Attempt the holding-register load, then go to IDLE.
  - SHIFT, `fs_q`=1: set `frame_err`. Discard the partial word and restart with this bit as bit 0 (`cnt`=1, stay in SHIFT).
- **Bit order.** With `MSB_FIRST`=1 the shifter shifts left and inserts at LSB; with `MSB_FIRST`=0 it shifts right and inserts at MSB. Either way, the first bit ends at the position given for `MSB_FIRST`.
- **Holding register load.**
  - A completed word loads if `rx_valid`=0, or if `rx_valid && rx_ready` on the same edge. In that case `rx_valid` stays 1 with the new data and no overflow is flagged.
  - Otherwise the word is dropped, `overflow` is set, and `rx_data` is unchanged.
- `rx_valid && rx_ready` with no completing word clears `rx_valid`.
- `rx_data` is stable whenever `rx_valid`=1 and no handshake occurs.
- **Sticky flags.** Setting takes priority over `clr_err` on the same edge.
- **Reset values.** `rx_data`=0, `rx_valid`=0, `overflow`=0, `frame_err`=0, `d_q`=`fs_q`=`en_q`=0, state IDLE, `cnt`=0. A reset mid-word discards the partial word; the next word requires a fresh `pad_fs`.

## Timing
- Pad to `d_q`: 1 edge.
- Last bit sampled from the pad at edge t (`sp`=1): `rx_valid`=1 with the full word after edge t+1. Latency is 2 edges from the last bit on the pad to the word visible.
- `sp` low cycles stretch the bit stream. Throughput is one bit per enabled cycle. Back-to-back words need no idle gap: `pad_fs` may assert on the bit immediately after a last bit.
- `rx_ready` has no combinational path to any output. `rx_valid` and `rx_data` are registered.

## Structure
- The package `ifd_pkg` holds the state enum `ifd_state_t` {IDLE, SHIFT} and a `WIDTH` legality check function, shared with the future DDR input variant.
- Sub-module `ifd_reg`: a 1-bit input flop with enable and asynchronous active-low reset. It is instantiated for `pad_d` and `pad_fs`.
- The top level contains the FSM, shifter, `cnt` ($clog2(`WIDTH`+1) bits), holding register and flags.

## Test plan
All scenarios use `WIDTH`=8 and `MSB_FIRST`=1 unless stated.
- **Single word.** `sp`=1, `rx_ready`=1; send bits 1,0,1,0,0,1,0,1 with `pad_fs` on the first bit. Required: `rx_data`=0xA5 and `rx_valid` high for 1 cycle, 2 edges after the last bit.
- **Bit order.** With `MSB_FIRST`=0, send the same bits. Required: `rx_data`=0xA5 reversed = 0xA5 (palindrome). Then send 1,1,0,0,0,0,0,0. Required: `rx_data`=0x03.
- **Enable gaps.** Send 0x3C with `sp`=0 on every other cycle. Required: `rx_data`=0x3C, no errors, `rx_valid` delayed by the stall count.
- **Overflow.** Hold `rx_ready`=0 and send 0x11 then 0x22 back-to-back. Required: `rx_data` stays 0x11 and `overflow`=1. Then pulse `clr_err`. Required: `overflow`=0.
- **Framing error.** Assert `pad_fs` on bit 4 of a word, then send 0x5A starting from that bit. Required: `frame_err`=1 and the next `rx_data`=0x5A.
- **Reset and simultaneous handshake.** Assert `resetn` low mid-word. Required: all outputs return to their reset values and the partial word is not emitted. Next, complete a word on the same edge as `rx_ready`=1 while `rx_valid`=1. Required: the new word replaces the old, `rx_valid` stays 1, and `overflow` stays 0.
